// File: rtl/ysyx_22050854_id_imm_ctrl_pkg.sv
// Shared definitions for the decode-stage immediate controller: ExtOP codes,
// RV64 major opcodes and the skid-buffer state encoding.
package ysyx_22050854_id_imm_ctrl_pkg;

    // Immediate format selector handed to the immediate generator.
    typedef enum logic [2:0] {
        EXT_I    = 3'b000,
        EXT_U    = 3'b001,
        EXT_S    = 3'b010,
        EXT_B    = 3'b011,
        EXT_J    = 3'b100,
        EXT_Z7   = 3'b101,
        EXT_NONE = 3'b111
    } ext_op_t;

    // Occupancy of the two-entry buffer (main register M, skid register S).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // RV64 major opcodes (instr[6:0]).
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Extract the major opcode field of a 32-bit instruction.
    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/ysyx_22050854_id_imm_ctrl_if.sv
// IF -> decode -> EX bundle for the immediate controller.
//
// Handshake: a beat transfers on a rising clock edge exactly when valid and
// ready are both high. A producer holding valid high keeps its payload stable
// until the transfer; the consumer's ready never depends combinationally on
// the producer's valid. On the IF side this block is the consumer (in_*), on
// the EX side it is the producer (out_*).
interface ysyx_22050854_id_imm_ctrl_if #(
    parameter int XLEN = 64
);
    import ysyx_22050854_id_imm_ctrl_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    ext_op_t         out_extop;
    logic            out_illegal;

    // Environment side: drives fetched instructions and the EX accept.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_extop, out_illegal
    );

    // Controller side.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_extop, out_illegal
    );

endinterface

// File: rtl/ysyx_22050854_imm_gen.sv
// Immediate generator: builds the XLEN-wide immediate of an instruction from
// the selected ExtOP format. Purely combinational.
module ysyx_22050854_imm_gen
    import ysyx_22050854_id_imm_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  ext_op_t         extop,
    output logic [XLEN-1:0] imm
);

    // Reassemble and extend the immediate bits scattered through the encoding.
    always_comb begin
        imm = '0;
        case (extop)
            EXT_I:  imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            EXT_U:  imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            EXT_S:  imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            EXT_B:  imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            EXT_J:  imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
            EXT_Z7: imm = {{(XLEN-7){1'b0}}, instr[6:0]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050854_id_imm_ctrl.sv
// Decode-stage sequencer: decodes the opcode of each fetched instruction into
// an ExtOP, computes its immediate on the way in, and hands complete entries
// to EX through a two-entry skid buffer. in_ready comes straight from a flop,
// so IF never sees a combinational path from the EX stall.
module ysyx_22050854_id_imm_ctrl
    import ysyx_22050854_id_imm_ctrl_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    ysyx_22050854_id_imm_ctrl_if.slave    bus,
    output state_t                        dbg_state
);

    // One buffered entry: everything EX needs, decoded once at capture time.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] imm;
        ext_op_t         extop;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{
        pc:      '0,
        instr:   '0,
        imm:     '0,
        extop:   EXT_NONE,
        illegal: 1'b0
    };

    state_t          state_q;
    logic            in_ready_q;
    entry_t          m_q;
    entry_t          s_q;

    logic [6:0]      opcode;
    ext_op_t         dec_extop;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    entry_t          in_entry;
    logic            out_valid;
    logic            accept;
    logic            retire;

    assign opcode = opcode_of(bus.in_instr);

    // Opcode -> ExtOP lookup with a default for everything not in the table.
    always_comb begin
        dec_extop   = EXT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                        dec_extop = EXT_U;
            OPC_JAL:                                   dec_extop = EXT_J;
            OPC_STORE:                                 dec_extop = EXT_S;
            OPC_BRANCH:                                dec_extop = EXT_B;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: dec_extop = EXT_I;
            OPC_SYSTEM:                                dec_extop = EXT_Z7;
            OPC_OP, OPC_OP32:                          dec_extop = EXT_NONE;
            default: begin
                dec_extop   = EXT_NONE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    ysyx_22050854_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (bus.in_instr),
        .extop (dec_extop),
        .imm   (dec_imm)
    );

    // Entry as it would be captured this cycle.
    always_comb begin
        in_entry         = ENTRY_RST;
        in_entry.pc      = bus.in_pc;
        in_entry.instr   = bus.in_instr;
        in_entry.imm     = dec_imm;
        in_entry.extop   = dec_extop;
        in_entry.illegal = dec_illegal;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign retire    = out_valid & bus.out_ready;

    // Skid-buffer sequencer: occupancy, registered in_ready and both entry
    // registers. in_ready is written alongside every state change so that it
    // always equals (state != TWO) without any combinational decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            m_q        <= ENTRY_RST;
            s_q        <= ENTRY_RST;
        end else if (flush) begin
            // A retire this cycle completes on the EX side regardless; any
            // accept this cycle is dropped along with the buffered entries.
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_q     <= in_entry;
                        state_q <= ST_ONE;
                    end
                    in_ready_q <= 1'b1;
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        m_q <= in_entry;
                    end else if (accept) begin
                        s_q        <= in_entry;
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (retire) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (retire) begin
                        m_q        <= s_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = m_q.pc;
    assign bus.out_instr   = m_q.instr;
    assign bus.out_imm     = m_q.imm;
    assign bus.out_extop   = m_q.extop;
    assign bus.out_illegal = m_q.illegal;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_ysyx_22050854_id_imm_ctrl.sv
// Bench for the decode-stage immediate controller: directed scenarios followed
// by randomized traffic, compared against a FIFO-of-depth-2 reference with an
// arithmetic immediate model.
module tb_ysyx_22050854_id_imm_ctrl;
    import ysyx_22050854_id_imm_ctrl_pkg::*;

    localparam int XLEN = 64;

    logic   clk;
    logic   rst_n;
    logic   flush;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] exp_pc_q[$];
    logic [31:0]     exp_instr_q[$];

    ysyx_22050854_id_imm_ctrl_if #(.XLEN(XLEN)) bus ();

    ysyx_22050854_id_imm_ctrl #(
        .XLEN (XLEN),
        .ILEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: immediate value computed as a signed integer from the
    // bit fields of each format.
    function automatic void model_decode(input logic [31:0] i, output logic [2:0] ext,
                                         output logic [63:0] imm, output logic ill);
        longint v;
        v   = 0;
        ext = 3'b111;
        ill = 1'b0;
        case (i[6:0])
            7'b0110111, 7'b0010111: begin
                ext = 3'b001;
                v = longint'(i[30:12]) * 64'sd4096;
                if (i[31]) v -= 64'sd2147483648;
            end
            7'b1101111: begin
                ext = 3'b100;
                v = longint'(i[19:12]) * 64'sd4096 + longint'(i[20]) * 64'sd2048
                  + longint'(i[30:21]) * 64'sd2;
                if (i[31]) v -= 64'sd1048576;
            end
            7'b0100011: begin
                ext = 3'b010;
                v = longint'(i[30:25]) * 64'sd32 + longint'(i[11:7]);
                if (i[31]) v -= 64'sd2048;
            end
            7'b1100011: begin
                ext = 3'b011;
                v = longint'(i[7]) * 64'sd2048 + longint'(i[30:25]) * 64'sd32
                  + longint'(i[11:8]) * 64'sd2;
                if (i[31]) v -= 64'sd4096;
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: begin
                ext = 3'b000;
                v = longint'(i[30:20]);
                if (i[31]) v -= 64'sd2048;
            end
            7'b1110011: begin
                ext = 3'b101;
                v = longint'(i[6:0]);
            end
            7'b0110011, 7'b0111011: begin
                ext = 3'b111;
            end
            default: begin
                ext = 3'b111;
                ill = 1'b1;
            end
        endcase
        imm = 64'(v);
    endfunction

    // Driver
    task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_instr"}, 64'(bus.out_instr), 64'd0);
        check({tag, "_out_pc"}, bus.out_pc, 64'd0);
        check({tag, "_out_imm"}, bus.out_imm, 64'd0);
        check({tag, "_out_extop"}, 64'(bus.out_extop), 64'd7);
        check({tag, "_out_illegal"}, 64'(bus.out_illegal), 64'd0);
    endtask

    // One clock: compare at the falling edge, then advance the reference at
    // the rising edge. Returns 1 time unit after the rising edge.
    task automatic cycle();
        logic       acc;
        logic       ret;
        logic [2:0] e;
        logic [63:0] im;
        logic       il;
        @(negedge clk);
        check("in_ready", 64'(bus.in_ready), 64'(exp_pc_q.size() < 2));
        check("out_valid", 64'(bus.out_valid), 64'(exp_pc_q.size() > 0));
        if (exp_pc_q.size() > 0) begin
            model_decode(exp_instr_q[0], e, im, il);
            check("out_pc", bus.out_pc, exp_pc_q[0]);
            check("out_instr", 64'(bus.out_instr), 64'(exp_instr_q[0]));
            check("out_imm", bus.out_imm, im);
            check("out_extop", 64'(bus.out_extop), 64'(e));
            check("out_illegal", 64'(bus.out_illegal), 64'(il));
        end
        acc = bus.in_valid && (exp_pc_q.size() < 2);
        ret = bus.out_ready && (exp_pc_q.size() > 0);
        @(posedge clk);
        if (flush) begin
            exp_pc_q.delete();
            exp_instr_q.delete();
        end else begin
            if (ret) begin
                void'(exp_pc_q.pop_front());
                void'(exp_instr_q.pop_front());
            end
            if (acc) begin
                exp_pc_q.push_back(bus.in_pc);
                exp_instr_q.push_back(bus.in_instr);
            end
        end
        #1;
    endtask

    logic [31:0] t2_instr [4] = '{32'h12345037, 32'h00112623, 32'hFE000EE3, 32'h008000EF};
    logic [63:0] t2_imm   [4] = '{64'h12345000, 64'hC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8};
    logic [6:0]  opcs     [14] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0100011,
                                   7'b1100011, 7'b1100111, 7'b0000011, 7'b0010011,
                                   7'b0011011, 7'b1110011, 7'b0110011, 7'b0111011,
                                   7'b1111111, 7'b0001111};

    // Stimulus
    initial begin
        logic [31:0] r;
        logic [31:0] ins;

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        check("rst_state", 64'(dbg_state), 64'(ST_EMPTY));
        rst_n = 1'b1;

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 64'h8000_0000, 1'b1, 1'b0);
        cycle();
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_extop", 64'(bus.out_extop), 64'd0);
        check("t1_pc", bus.out_pc, 64'h8000_0000);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle();

        // back-to-back stream, one per cycle
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, t2_instr[k], 64'h8000_0100 + 64'(k * 4), 1'b1, 1'b0);
            cycle();
            check("t2_imm", bus.out_imm, t2_imm[k]);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle();
        cycle();

        // EX stalled: fill both entries, third offer refused, outputs frozen
        drive(1'b1, 32'h00100093, 64'h1000, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h00200113, 64'h1004, 1'b0, 1'b0);
        cycle();
        check("t3_in_ready_full", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 32'h00300193, 64'h1008, 1'b0, 1'b0);
        cycle();
        check("t3_frozen_pc", bus.out_pc, 64'h1000);
        check("t3_frozen_imm", bus.out_imm, 64'd1);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle();
        check("t3_second_pc", bus.out_pc, 64'h1004);
        check("t3_in_ready_back", 64'(bus.in_ready), 64'd1);
        cycle();
        check("t3_drained", 64'(bus.out_valid), 64'd0);

        // flush while full with a concurrent offer
        drive(1'b1, 32'h00400213, 64'h2000, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h00500293, 64'h2004, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h00600313, 64'h2008, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("t4_valid_after_flush", 64'(bus.out_valid), 64'd0);
        check("t4_ready_after_flush", 64'(bus.in_ready), 64'd1);
        cycle();
        drive(1'b1, 32'h00700393, 64'h200C, 1'b1, 1'b0);
        cycle();
        check("t4_next_pc", bus.out_pc, 64'h200C);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle();

        // illegal opcode and register-register op
        drive(1'b1, 32'h0000007F, 64'h3000, 1'b1, 1'b0);
        cycle();
        check("t5_illegal", 64'(bus.out_illegal), 64'd1);
        check("t5_ill_extop", 64'(bus.out_extop), 64'd7);
        check("t5_ill_imm", bus.out_imm, 64'd0);
        drive(1'b1, 32'h002081B3, 64'h3004, 1'b1, 1'b0);
        cycle();
        check("t5_add_illegal", 64'(bus.out_illegal), 64'd0);
        check("t5_add_imm", bus.out_imm, 64'd0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle();

        // asynchronous reset between clock edges with entries buffered
        drive(1'b1, 32'h12345037, 64'h4000, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h00112623, 64'h4004, 1'b0, 1'b0);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6");
        exp_pc_q.delete();
        exp_instr_q.delete();
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h02A00093, 64'h5000, 1'b1, 1'b0);
        cycle();
        check("t6_first_imm", bus.out_imm, 64'd42);
        check("t6_first_pc", bus.out_pc, 64'h5000);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r   = $urandom();
            ins = {r[31:7], opcs[$urandom_range(0, 13)]};
            drive($urandom_range(0, 3) != 0, ins, {$urandom(), $urandom()},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            cycle();
        end

        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
